branch_target_buffer: RTL and testbench
=======================================

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 Parameter ENTRY_BITS, default 4, log2 of entry count (16 entries).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 PCF  in  32  fetch-stage PC for lookup.
REQ-005 PredictedF  out  1  predict taken for PCF; travels down pipeline to become PredictedE.
REQ-006 PredictedPCF  out  32  next fetch PC: stored target if PredictedF, else PCF+4.
REQ-007 EnE  in  1  EX stage advancing (not stalled); gates updates and statistics.
REQ-008 BranchE  in  1  valid conditional branch resolved in EX this cycle.
REQ-009 BrTakenE  in  1  actual branch outcome.
REQ-010 PCE  in  32  PC of the EX instruction.
REQ-011 BrTargetE  in  32  computed branch target.
REQ-012 PredictedE  in  1  prediction made for the EX instruction.
REQ-013 MispredictE  out  1  flush IF/ID and redirect fetch.
REQ-014 CorrectNPCE  out  32  redirect PC when MispredictE.

Function
REQ-015 Per entry: valid, tag PC[31:ENTRY_BITS+2], target[31:0], 2-bit counter; index PC[ENTRY_BITS+1:2]; direct-mapped.
REQ-016 Lookup combinational, zero latency: hit = valid & tag match at PCF index; PredictedF = hit & counter[1].
REQ-017 PredictedPCF = PredictedF ? target : PCF+4; 32-bit add, wraps modulo 2^32.
REQ-018 Update only when EnE & BranchE, applied at posedge clk; no update otherwise.
REQ-019 Update on hit at PCE: counter saturating +1 if taken, -1 if not taken (00 floor, 11 ceiling); on taken, target <= BrTargetE.
REQ-020 Update on miss, taken: allocate/replace entry: valid=1, tag from PCE, target=BrTargetE, counter=10 (weakly taken).
REQ-021 Update on miss, not taken: no allocation; state unchanged.
REQ-022 MispredictE = BranchE & (PredictedE != BrTakenE), combinational; forced 0 when BranchE=0, whatever PredictedE.
REQ-023 CorrectNPCE = BrTakenE ? BrTargetE : PCE+4.
REQ-024 Same-cycle lookup and update of one index: lookup returns pre-update contents; new state visible next cycle.
REQ-025 Target correctness is not checked; only direction mispredicts are detected.

Reset
REQ-026 rst wins over any update in the same cycle and clears all valid bits and counters to 00; targets/tags need not be cleared.
REQ-027 After reset, PredictedF=0, PredictedPCF=PCF+4 for every PCF.
REQ-028 Reset mid-operation discards all entries; the first post-reset update behaves as a miss.

Configuration
REQ-029 Macro BTB_STATS_EN: when defined, adds outputs BranchCount[31:0] and MissCount[31:0], both reset to 0.
REQ-030 With BTB_STATS_EN, BranchCount increments on each EnE & BranchE and MissCount on each EnE & MispredictE; both saturate at 32'hFFFF_FFFF.
REQ-031 Without BTB_STATS_EN, no such ports or counters exist; all other behaviour is identical.

Structure
REQ-032 Shared package btb_pkg holds counter encodings (STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11) and the allocation value WEAK_T.
REQ-033 One sub-module btb_sat_counter: 2-bit saturating next-state logic from (cnt, taken); instantiated once, in the update path.

Verification
REQ-034 Reset, then PCF=0x100 -> PredictedF=0, PredictedPCF=0x104.
REQ-035 Branch PCE=0x100, taken, target 0x80, PredictedE=0 -> MispredictE=1, CorrectNPCE=0x80; next cycle PCF=0x100 gives PredictedF=1, PredictedPCF=0x80.
REQ-036 Same branch resolved not-taken twice with PredictedE=1 -> counter 10->01->00; PredictedF=0 after the first; MispredictE=1, CorrectNPCE=0x104.
REQ-037 Aliasing: PCE=0x140 (same index as 0x100 at ENTRY_BITS=4, different tag) taken, target 0x200 -> entry replaced; PCF=0x100 misses, PCF=0x140 predicts 0x200.
REQ-038 EnE=0 with BranchE=1, taken -> no state change; BTB_STATS_EN counters unchanged; rst asserted with an update -> all entries invalid.
REQ-039 Counter saturation: four consecutive taken resolutions -> counter stays 11; one not-taken -> 10, still predicts taken.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types for the branch target buffer.
// Counter encodings and the value a new entry starts with.
package btb_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_e;

  localparam ctr_e ALLOC_CTR = WEAK_T;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  function automatic logic ctr_taken(input ctr_e c);
    return c[1];
  endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// 2-bit saturating direction counter, next-state only.
// Moves toward taken or not-taken and sticks at either end.
module btb_sat_counter
  import btb_pkg::*;
(
  input  ctr_e i_cnt,
  input  logic i_taken,
  output ctr_e o_cnt
);

  always_comb begin
    o_cnt = i_cnt;
    unique case (1'b1)
      (i_taken && (i_cnt != STRONG_T)):
        o_cnt = ctr_e'(i_cnt + 2'd1);
      (!i_taken && (i_cnt != STRONG_NT)):
        o_cnt = ctr_e'(i_cnt - 2'd1);
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Define BTB_STATS_EN to add BranchCount/MissCount statistics ports.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int ENTRY_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        PredictedF,
  output logic [31:0] PredictedPCF,
  input  logic        EnE,
  input  logic        BranchE,
  input  logic        BrTakenE,
  input  logic [31:0] PCE,
  input  logic [31:0] BrTargetE,
  input  logic        PredictedE,
  output logic        MispredictE,
  output logic [31:0] CorrectNPCE
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] BranchCount,
  output logic [31:0] MissCount
`endif
);

  localparam int N     = 1 << ENTRY_BITS;
  localparam int TAG_W = 30 - ENTRY_BITS;

  logic             r_valid  [N];
  logic [TAG_W-1:0] r_tag    [N];
  logic [31:0]      r_target [N];
  ctr_e             r_ctr    [N];

  logic [ENTRY_BITS-1:0] w_f_idx;
  logic [TAG_W-1:0]      w_f_tag;
  logic                  w_f_hit;

  logic [ENTRY_BITS-1:0] w_e_idx;
  logic [TAG_W-1:0]      w_e_tag;
  logic                  w_e_hit;
  logic                  w_upd;
  logic                  w_alloc;
  logic                  w_tgt_wr;
  ctr_e                  w_ctr_nxt;
  logic                  w_unused;

  assign w_unused = ^{PCF[1:0], PCE[1:0]};

  // Fetch-side lookup reads pre-update state
  assign w_f_idx = PCF[ENTRY_BITS+1:2];
  assign w_f_tag = PCF[31:ENTRY_BITS+2];
  assign w_f_hit = r_valid[w_f_idx]
                && (r_tag[w_f_idx] == w_f_tag);

  assign PredictedF   = w_f_hit
                     && ctr_taken(r_ctr[w_f_idx]);
  assign PredictedPCF = PredictedF
                      ? r_target[w_f_idx]
                      : PCF + INSTR_BYTES;

  assign MispredictE = BranchE
                    && (PredictedE != BrTakenE);
  assign CorrectNPCE = BrTakenE
                     ? BrTargetE
                     : PCE + INSTR_BYTES;

  assign w_e_idx = PCE[ENTRY_BITS+1:2];
  assign w_e_tag = PCE[31:ENTRY_BITS+2];
  assign w_e_hit = r_valid[w_e_idx]
                && (r_tag[w_e_idx] == w_e_tag);

  assign w_upd    = EnE && BranchE;
  assign w_alloc  = w_upd && !w_e_hit && BrTakenE;
  assign w_tgt_wr = w_upd && BrTakenE;

  btb_sat_counter u_ctr (
    .i_cnt   (r_ctr[w_e_idx]),
    .i_taken (BrTakenE),
    .o_cnt   (w_ctr_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= STRONG_NT;
      end
    end else if (w_upd && w_e_hit) begin
      r_ctr[w_e_idx] <= w_ctr_nxt;
    end else if (w_alloc) begin
      r_valid[w_e_idx] <= 1'b1;
      r_ctr[w_e_idx]   <= ALLOC_CTR;
    end
  end

  // Tag rewrite on a hit is harmless: it is already equal
  always_ff @(posedge clk) begin
    if (!rst && w_tgt_wr) begin
      r_tag[w_e_idx]    <= w_e_tag;
      r_target[w_e_idx] <= BrTargetE;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] r_branch_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_cnt <= '0;
      r_miss_cnt   <= '0;
    end else begin
      if (w_upd && (r_branch_cnt != '1))
        r_branch_cnt <= r_branch_cnt + 32'd1;
      if (EnE && MispredictE && (r_miss_cnt != '1))
        r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign BranchCount = r_branch_cnt;
  assign MissCount   = r_miss_cnt;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Randomized bench for branch_target_buffer against a behavioural model.
// Honours BTB_STATS_EN when the build defines it.
module tb_branch_target_buffer;

  localparam int EB = 4;
  localparam int NE = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF;
  logic        PredictedF;
  logic [31:0] PredictedPCF;
  logic        EnE, BranchE, BrTakenE, PredictedE;
  logic [31:0] PCE, BrTargetE;
  logic        MispredictE;
  logic [31:0] CorrectNPCE;
`ifdef BTB_STATS_EN
  logic [31:0] BranchCount, MissCount;
`endif

  int n_chk = 0;
  int n_err = 0;
  bit run = 0;

  always #5 clk = ~clk;

  branch_target_buffer #(.ENTRY_BITS(EB)) dut (
    .clk          (clk),
    .rst          (rst),
    .PCF          (PCF),
    .PredictedF   (PredictedF),
    .PredictedPCF (PredictedPCF),
    .EnE          (EnE),
    .BranchE      (BranchE),
    .BrTakenE     (BrTakenE),
    .PCE          (PCE),
    .BrTargetE    (BrTargetE),
    .PredictedE   (PredictedE),
    .MispredictE  (MispredictE),
    .CorrectNPCE  (CorrectNPCE)
`ifdef BTB_STATS_EN
    ,
    .BranchCount  (BranchCount),
    .MissCount    (MissCount)
`endif
  );

  // Model: each slot remembers the full branch PC it holds
  bit          m_valid [NE];
  logic [31:0] m_pc    [NE];
  logic [31:0] m_tgt   [NE];
  int          m_ctr   [NE];
  longint      m_bc, m_mc;

  function automatic int slot(logic [31:0] pc);
    return int'((pc / 4) % NE);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    int s = slot(pc);
    return m_valid[s]
        && ((m_pc[s] >> (EB + 2)) == (pc >> (EB + 2)));
  endfunction

  function automatic bit m_pred(logic [31:0] pc);
    return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_npc(logic [31:0] pc);
    return m_pred(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
  endfunction

  always @(posedge clk) begin
    int s;
    s = slot(PCE);
    if (rst) begin
      for (int i = 0; i < NE; i++) begin
        m_valid[i] = 0;
        m_ctr[i]   = 0;
      end
      m_bc = 0;
      m_mc = 0;
    end else if (EnE && BranchE) begin
      if (m_hit(PCE)) begin
        if (BrTakenE) begin
          m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
          m_tgt[s] = BrTargetE;
        end else begin
          m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
        end
      end else if (BrTakenE) begin
        m_valid[s] = 1;
        m_pc[s]    = PCE;
        m_tgt[s]   = BrTargetE;
        m_ctr[s]   = 2;
      end
      m_bc = (m_bc == 64'hFFFF_FFFF) ? m_bc : m_bc + 1;
      if (PredictedE != BrTakenE)
        m_mc = (m_mc == 64'hFFFF_FFFF) ? m_mc : m_mc + 1;
    end
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("PredictedF", 32'(PredictedF), 32'(m_pred(PCF)));
      chk("PredictedPCF", PredictedPCF, m_npc(PCF));
      chk("MispredictE", 32'(MispredictE),
          32'(BranchE && (PredictedE != BrTakenE)));
      chk("CorrectNPCE", CorrectNPCE,
          BrTakenE ? BrTargetE : PCE + 32'd4);
`ifdef BTB_STATS_EN
      chk("BranchCount", BranchCount, 32'(m_bc));
      chk("MissCount", MissCount, 32'(m_mc));
`endif
    end
  end

  task automatic drive(bit r, bit en, bit br, bit tk,
                       logic [31:0] pce, logic [31:0] tgt,
                       bit pe, logic [31:0] pcf);
    @(posedge clk);
    #1;
    rst        = r;
    EnE        = en;
    BranchE    = br;
    BrTakenE   = tk;
    PCE        = pce;
    BrTargetE  = tgt;
    PredictedE = pe;
    PCF        = pcf;
    @(negedge clk);
  endtask

  task automatic idle(logic [31:0] pcf);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0, pcf);
  endtask

  logic [31:0] r_pce, r_pcf;

  initial begin
    rst = 1; EnE = 0; BranchE = 0; BrTakenE = 0;
    PCE = 0; BrTargetE = 0; PredictedE = 0; PCF = 0;
    @(posedge clk);
    #1;
    run = 1;

    idle(32'h100);
    chk("rst_pf", 32'(PredictedF), 32'd0);
    chk("rst_ppc", PredictedPCF, 32'h104);

    drive(0, 1, 1, 1, 32'h100, 32'h80, 0, 32'h100);
    chk("alloc_mp", 32'(MispredictE), 32'd1);
    chk("alloc_npc", CorrectNPCE, 32'h80);
    chk("same_cyc_pf", 32'(PredictedF), 32'd0);
    idle(32'h100);
    chk("alloc_pf", 32'(PredictedF), 32'd1);
    chk("alloc_ppc", PredictedPCF, 32'h80);

    drive(0, 1, 1, 0, 32'h100, 32'h80, 1, 32'h100);
    chk("nt1_mp", 32'(MispredictE), 32'd1);
    chk("nt1_npc", CorrectNPCE, 32'h104);
    idle(32'h100);
    chk("nt1_pf", 32'(PredictedF), 32'd0);
    drive(0, 1, 1, 0, 32'h100, 32'h80, 1, 32'h100);
    chk("nt2_mp", 32'(MispredictE), 32'd1);
    idle(32'h100);
    chk("nt2_pf", 32'(PredictedF), 32'd0);

    drive(0, 1, 1, 1, 32'h140, 32'h200, 0, 32'h140);
    chk("alias_pre", 32'(PredictedF), 32'd0);
    idle(32'h100);
    chk("alias_old_pf", 32'(PredictedF), 32'd0);
    chk("alias_old_ppc", PredictedPCF, 32'h104);
    idle(32'h140);
    chk("alias_new_pf", 32'(PredictedF), 32'd1);
    chk("alias_new_ppc", PredictedPCF, 32'h200);

    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 1, 32'h140, 32'h200, 1, 32'h140);
      chk("sat_mp", 32'(MispredictE), 32'd0);
    end
    drive(0, 1, 1, 0, 32'h140, 32'h200, 1, 32'h140);
    idle(32'h140);
    chk("sat_pf", 32'(PredictedF), 32'd1);
    chk("sat_ppc", PredictedPCF, 32'h200);

    drive(0, 1, 0, 0, 32'h0, 32'h0, 1, 32'h140);
    chk("nobr_mp", 32'(MispredictE), 32'd0);

    drive(0, 0, 1, 1, 32'h300, 32'h400, 0, 32'h300);
    idle(32'h300);
    chk("ene0_pf", 32'(PredictedF), 32'd0);

    drive(1, 1, 1, 1, 32'h300, 32'h400, 0, 32'h300);
    idle(32'h300);
    chk("rstupd_pf", 32'(PredictedF), 32'd0);
`ifdef BTB_STATS_EN
    chk("rst_bc", BranchCount, 32'd0);
`endif
    idle(32'h140);
    chk("rst_clr_pf", 32'(PredictedF), 32'd0);
    chk("rst_clr_ppc", PredictedPCF, 32'h144);

    drive(0, 1, 1, 1, 32'h140, 32'h500, 0, 32'h140);
    idle(32'h140);
    chk("post_rst_pf", 32'(PredictedF), 32'd1);
    chk("post_rst_ppc", PredictedPCF, 32'h500);

    idle(32'hFFFF_FFFC);
    chk("wrap_ppc", PredictedPCF, 32'h0);

    for (int c = 0; c < 3000; c++) begin
      r_pce = ($urandom_range(0, 3) << 6)
            | ($urandom_range(0, 15) << 2);
      r_pcf = ($urandom_range(0, 3) << 6)
            | ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 9) == 0) r_pce = $urandom;
      if ($urandom_range(0, 9) == 0) r_pcf = $urandom;
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 2) != 0),
            $urandom_range(0, 1),
            r_pce, $urandom,
            ($urandom_range(0, 3) != 0)
              ? m_pred(r_pce) : 1'($urandom_range(0, 1)),
            r_pcf);
    end

    idle(32'h0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
